ws2812_rx: RTL and testbench

//  Receiver/decoder for the WS2812 single-wire NRZ protocol driven by ws2812. Measures high-pulse

---
 rtl/ws2812_rx_if.sv | 34 +++
 rtl/ws2812_rx.sv | 208 ++++++++++++++++++++
 tb/tb_ws2812_rx.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ws2812_rx_if.sv
// rtl/ws2812_rx_if.sv - signal bundle between the WS2812 receiver and its consumer
//
// Purpose: groups the serial input and the decoded-word outputs of ws2812_rx.
//   Build option WS2812_RX_REPEATER_EN adds the repeated serial output dout.
// Signals:
//   data        serial WS2812 line into the receiver (asynchronous to clk)
//   rgb_colour  last decoded word {green, red, blue}, first received bit in bit 23
//   led_index   position of that word in the frame (0 = first after latch)
//   valid       one-cycle strobe, rgb_colour/led_index updated
//   frame_done  one-cycle strobe, latch gap seen after at least one bit
//   error       one-cycle strobe, over-long high pulse or partial word at latch
//   dout        (WS2812_RX_REPEATER_EN only) pixel-style DOUT stream
// Modports: master = receiver side, slave = line driver / word consumer side.
interface ws2812_rx_if #(
  parameter int NUM_LEDS = 4
);
  localparam int IW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  logic          data;
  logic [23:0]   rgb_colour;
  logic [IW-1:0] led_index;
  logic          valid;
  logic          frame_done;
  logic          error;
`ifdef WS2812_RX_REPEATER_EN
  logic          dout;

  modport master (input data, output rgb_colour, led_index, valid, frame_done, error, dout);
  modport slave  (output data, input rgb_colour, led_index, valid, frame_done, error, dout);
`else
  modport master (input data, output rgb_colour, led_index, valid, frame_done, error);
  modport slave  (output data, input rgb_colour, led_index, valid, frame_done, error);
`endif
endinterface

// File: rtl/ws2812_rx.sv
// rtl/ws2812_rx.sv - WS2812 NRZ receiver: pulse-width decoder, word assembly, latch detection
//
// Purpose: measures high-pulse widths on the synchronised serial line, rebuilds 24-bit GRB
//   words, reports each with its LED index, and detects the end-of-frame latch gap.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous, active-high reset
//   bus    ws2812_rx_if.master: data in; rgb_colour, led_index, valid, frame_done, error out
// Build option: WS2812_RX_REPEATER_EN adds bus.dout, which repeats the line like a pixel's
//   DOUT once the first NUM_LEDS words have been consumed.
module ws2812_rx #(
  parameter int NUM_LEDS    = 4,
  parameter int CLK_MHZ     = 12,
  parameter int THRESH_NS   = 550,
  parameter int MAX_HIGH_NS = 2000,
  parameter int RESET_US    = 50
) (
  input  logic         clk,
  input  logic         reset,
  ws2812_rx_if.master  bus
);
  localparam int THRESH_CYC = CLK_MHZ * THRESH_NS / 1000;
  localparam int MAXH_CYC   = CLK_MHZ * MAX_HIGH_NS / 1000;
  localparam int RESET_CYC  = CLK_MHZ * RESET_US;
  localparam int CW = $clog2(RESET_CYC + 1);
  localparam int IW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int WW = $clog2(NUM_LEDS + 1);

  localparam logic [CW-1:0] THRESH_C = CW'(THRESH_CYC);
  localparam logic [CW-1:0] MAXH_C   = CW'(MAXH_CYC);
  localparam logic [CW-1:0] RESET_C  = CW'(RESET_CYC);
  localparam logic [WW-1:0] NUM_W    = WW'(NUM_LEDS);
  localparam logic [WW-1:0] LAST_W   = WW'(NUM_LEDS - 1);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_sync1, r_ds, r_ds_d;
  logic          w_rise, w_fall, w_bit;
  logic [CW-1:0] r_high_cnt, w_high_nxt, r_low_cnt, w_low_nxt, w_inc_high, w_inc_low;
  logic [23:0]   r_sreg, w_sreg_nxt;
  logic [4:0]    r_bit_cnt, w_bit_nxt;
  logic [WW-1:0] r_word_cnt, w_word_nxt;
  logic          r_pend, w_pend_nxt;
  logic [IW-1:0] r_pend_idx, w_pend_idx_nxt;
  logic          w_frame_done, w_error;
  logic [23:0]   r_rgb;
  logic [IW-1:0] r_led_index;
  logic          r_valid, r_frame_done, r_error;
`ifdef WS2812_RX_REPEATER_EN
  logic          r_fwd, w_fwd_nxt, r_dout;
`endif

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  assign w_rise     = r_ds & ~r_ds_d;
  assign w_fall     = ~r_ds & r_ds_d;
  assign w_inc_high = sat_inc(r_high_cnt);
  assign w_inc_low  = sat_inc(r_low_cnt);

  always_comb begin
    w_state_nxt    = r_state;
    w_high_nxt     = r_high_cnt;
    w_low_nxt      = r_low_cnt;
    w_sreg_nxt     = r_sreg;
    w_bit_nxt      = r_bit_cnt;
    w_word_nxt     = r_word_cnt;
    w_pend_nxt     = 1'b0;
    w_pend_idx_nxt = r_pend_idx;
    w_frame_done   = 1'b0;
    w_error        = 1'b0;
    w_bit          = 1'b0;
`ifdef WS2812_RX_REPEATER_EN
    w_fwd_nxt      = r_fwd;
`endif
    case (r_state)
      // Alignment: only a full latch-length low period proves we are between frames.
      SYNC: begin
        if (r_ds) begin
          w_low_nxt = '0;
        end else if (w_inc_low >= RESET_C) begin
          w_low_nxt   = '0;
          w_state_nxt = IDLE;
        end else begin
          w_low_nxt = w_inc_low;
        end
      end
      IDLE: begin
        if (w_rise) begin
          w_high_nxt  = CW'(1);
          w_state_nxt = HIGH;
        end
      end
      HIGH: begin
        if (w_fall) begin
          w_bit       = (r_high_cnt >= THRESH_C);
          w_low_nxt   = CW'(1);
          w_state_nxt = LOW;
          // Words beyond NUM_LEDS belong to downstream pixels and are not captured.
          if (r_word_cnt < NUM_W) begin
            w_sreg_nxt = {r_sreg[22:0], w_bit};
            if (r_bit_cnt == 5'd23) begin
              w_bit_nxt      = '0;
              w_word_nxt     = r_word_cnt + WW'(1);
              w_pend_nxt     = 1'b1;
              w_pend_idx_nxt = IW'(r_word_cnt);
`ifdef WS2812_RX_REPEATER_EN
              if (r_word_cnt == LAST_W) w_fwd_nxt = 1'b1;
`endif
            end else begin
              w_bit_nxt = r_bit_cnt + 5'd1;
            end
          end
        end else if (w_inc_high > MAXH_C) begin
          w_error     = 1'b1;
          w_bit_nxt   = '0;
          w_word_nxt  = '0;
          w_low_nxt   = '0;
          w_state_nxt = SYNC;
`ifdef WS2812_RX_REPEATER_EN
          w_fwd_nxt   = 1'b0;
`endif
        end else begin
          w_high_nxt = w_inc_high;
        end
      end
      LOW: begin
        if (w_rise) begin
          w_high_nxt  = CW'(1);
          w_state_nxt = HIGH;
        end else if (w_inc_low >= RESET_C) begin
          w_frame_done = 1'b1;
          w_error      = (r_bit_cnt != 5'd0);
          w_bit_nxt    = '0;
          w_word_nxt   = '0;
          w_low_nxt    = '0;
          w_state_nxt  = IDLE;
`ifdef WS2812_RX_REPEATER_EN
          w_fwd_nxt    = 1'b0;
`endif
        end else begin
          w_low_nxt = w_inc_low;
        end
      end
      default: w_state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1      <= 1'b0;
      r_ds         <= 1'b0;
      r_ds_d       <= 1'b0;
      r_state      <= SYNC;
      r_high_cnt   <= '0;
      r_low_cnt    <= '0;
      r_sreg       <= '0;
      r_bit_cnt    <= '0;
      r_word_cnt   <= '0;
      r_pend       <= 1'b0;
      r_pend_idx   <= '0;
      r_rgb        <= '0;
      r_led_index  <= '0;
      r_valid      <= 1'b0;
      r_frame_done <= 1'b0;
      r_error      <= 1'b0;
`ifdef WS2812_RX_REPEATER_EN
      r_fwd        <= 1'b0;
      r_dout       <= 1'b0;
`endif
    end else begin
      r_sync1      <= bus.data;
      r_ds         <= r_sync1;
      r_ds_d       <= r_ds;
      r_state      <= w_state_nxt;
      r_high_cnt   <= w_high_nxt;
      r_low_cnt    <= w_low_nxt;
      r_sreg       <= w_sreg_nxt;
      r_bit_cnt    <= w_bit_nxt;
      r_word_cnt   <= w_word_nxt;
      r_pend       <= w_pend_nxt;
      r_pend_idx   <= w_pend_idx_nxt;
      // The completed word sits in r_sreg for one cycle before being published.
      r_valid      <= r_pend;
      if (r_pend) begin
        r_rgb       <= r_sreg;
        r_led_index <= r_pend_idx;
      end
      r_frame_done <= w_frame_done;
      r_error      <= w_error;
`ifdef WS2812_RX_REPEATER_EN
      r_fwd        <= w_fwd_nxt;
      r_dout       <= r_fwd & r_ds;
`endif
    end
  end

  assign bus.rgb_colour = r_rgb;
  assign bus.led_index  = r_led_index;
  assign bus.valid      = r_valid;
  assign bus.frame_done = r_frame_done;
  assign bus.error      = r_error;
`ifdef WS2812_RX_REPEATER_EN
  assign bus.dout       = r_dout;
`endif
endmodule

// File: tb/tb_ws2812_rx.sv
// tb/tb_ws2812_rx.sv - scoreboard testbench for ws2812_rx with randomized pulse widths
`timescale 1ns/1ps
module tb_ws2812_rx;
  localparam int NUM_LEDS   = 4;
  localparam int THRESH_CYC = 6;
  localparam int MAXH_CYC   = 24;
  localparam int RESET_CYC  = 600;
  localparam int GAP        = 720;

  typedef struct packed {
    logic [23:0] word;
    logic [31:0] idx;
    logic [31:0] at;
  } vexp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  vexp_t      vq[$];
  logic [1:0] eq[$];
  vexp_t      ve;
  logic [1:0] ee;

  bit          m_sync = 1'b1;
  bit          m_any = 1'b0;
  logic [23:0] m_word = '0;
  int          m_nbits = 0;
  int          m_nwords = 0;
  bit          fwd_now = 1'b0;

  ws2812_rx_if #(.NUM_LEDS(NUM_LEDS)) bus ();

  ws2812_rx #(
    .NUM_LEDS(NUM_LEDS), .CLK_MHZ(12), .THRESH_NS(550), .MAX_HIGH_NS(2000), .RESET_US(50)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_frame();
    m_any = 1'b0;
    m_nbits = 0;
    m_nwords = 0;
    fwd_now = 1'b0;
  endtask

  // One high pulse of h cycles followed by l low cycles; expectations are queued first.
  task automatic pulse(input int h, input int l);
    int fall_at;
    fall_at = cyc + h;
    if (h > MAXH_CYC) begin
      if (!m_sync) eq.push_back(2'b01);
      m_sync = 1'b1;
      clear_frame();
    end else if (!m_sync) begin
      m_any = 1'b1;
      if (m_nwords < NUM_LEDS) begin
        m_word = {m_word[22:0], (h >= THRESH_CYC) ? 1'b1 : 1'b0};
        m_nbits++;
        if (m_nbits == 24) begin
          vq.push_back({m_word, 32'(m_nwords), 32'(fall_at + 4)});
          m_nwords++;
          m_nbits = 0;
        end
      end else begin
        fwd_now = 1'b1;
      end
    end
    bus.data = 1'b1;
    repeat (h) tick();
    bus.data = 1'b0;
    repeat (l) tick();
  endtask

  task automatic gap(input int n);
    bus.data = 1'b0;
    if (n >= RESET_CYC) begin
      if (!m_sync && m_any) eq.push_back({1'b1, (m_nbits != 0) ? 1'b1 : 1'b0});
      m_sync = 1'b0;
      clear_frame();
    end
    repeat (n) tick();
  endtask

  // Top n bits of w, MSB first; fixed=1 uses exactly h0/h1 high cycles for 0/1 bits.
  task automatic send_bits(input logic [23:0] w, input int n, input bit fixed, input int h0, input int h1);
    for (int i = 23; i > 23 - n; i--) begin
      int h;
      if (fixed) h = w[i] ? h1 : h0;
      else       h = w[i] ? int'($urandom_range(12, 6)) : int'($urandom_range(5, 3));
      pulse(h, int'($urandom_range(11, 7)));
    end
  endtask

  task automatic send_word(input logic [23:0] w);
    send_bits(w, 24, 1'b0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    bus.data = 1'b0;
    repeat (n) tick();
    chk("reset_rgb", 32'(bus.rgb_colour), 32'h0);
    chk("reset_idx", 32'(bus.led_index), 32'h0);
    chk("reset_valid", 32'(bus.valid), 32'h0);
    chk("reset_frame_done", 32'(bus.frame_done), 32'h0);
    chk("reset_error", 32'(bus.error), 32'h0);
    reset = 1'b0;
    m_sync = 1'b1;
    clear_frame();
    tick();
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.valid) begin
        chk("valid_expected", 32'(vq.size() > 0), 32'h1);
        if (vq.size() > 0) begin
          ve = vq.pop_front();
          chk("rgb_colour", 32'(bus.rgb_colour), 32'(ve.word));
          chk("led_index", 32'(bus.led_index), ve.idx);
          chk("valid_cycle", 32'(cyc), ve.at);
        end
      end
      if (bus.frame_done || bus.error) begin
        chk("strobe_expected", 32'(eq.size() > 0), 32'h1);
        if (eq.size() > 0) begin
          ee = eq.pop_front();
          chk("frame_done_error", 32'({bus.frame_done, bus.error}), 32'(ee));
        end
      end
    end
  end

`ifdef WS2812_RX_REPEATER_EN
  logic hist_d [0:7];
  logic hist_f [0:7];
  always @(negedge clk) begin
    hist_d[3'(cyc)] = bus.data;
    hist_f[3'(cyc)] = fwd_now;
    if (!reset && cyc > 8)
      chk("dout", 32'(bus.dout), 32'(hist_d[3'(cyc - 3)] & hist_f[3'(cyc - 3)]));
  end
`endif

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [23:0] w;
    int nw, nb;
    bus.data = 1'b0;
    do_reset(4);
    gap(GAP);

    // single word
    send_word(24'h102030);
    gap(GAP);

    // four fixed words
    send_word(24'hFF0000);
    send_word(24'h00FF00);
    send_word(24'h0000FF);
    send_word(24'hA5A5A5);
    gap(GAP);

    // six words: last two dropped (forwarded when repeating)
    for (int i = 0; i < 6; i++) send_word(24'($urandom));
    gap(GAP);

    // partial word at latch, then a fresh frame from index 0
    send_bits(24'($urandom), 13, 1'b0, 0, 0);
    gap(GAP);
    send_word(24'($urandom));
    gap(GAP);

    // over-long high pulse mid-word, trailing bits ignored until a latch gap
    send_word(24'($urandom));
    send_bits(24'($urandom), 10, 1'b0, 0, 0);
    pulse(30, 10);
    send_bits(24'($urandom), 14, 1'b0, 0, 0);
    gap(GAP);
    send_word(24'($urandom));
    send_word(24'($urandom));
    gap(GAP);

    // decision boundary: 5 cycles -> 0, 6 cycles -> 1
    send_bits(24'hC3A55A, 24, 1'b1, THRESH_CYC - 1, THRESH_CYC);
    send_bits(24'h3C5AA5, 24, 1'b1, THRESH_CYC - 1, THRESH_CYC);
    gap(GAP);

    // reset in the middle of word 2
    send_word(24'h123456);
    send_bits(24'($urandom), 9, 1'b0, 0, 0);
    do_reset(2);
    send_bits(24'($urandom), 15, 1'b0, 0, 0);
    send_word(24'($urandom));
    gap(GAP);
    send_word(24'($urandom));
    gap(GAP);

    // random frames
    for (int f = 0; f < 5; f++) begin
      nw = int'($urandom_range(6, 1));
      nb = int'($urandom_range(23, 0));
      for (int i = 0; i < nw; i++) begin
        w = 24'($urandom);
        send_word(w);
      end
      if (f[0]) send_bits(24'($urandom), nb, 1'b0, 0, 0);
      gap(GAP);
    end

    repeat (10) tick();
    chk("leftover_valids", 32'(vq.size()), 32'h0);
    chk("leftover_strobes", 32'(eq.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
